simple_bus_node: RTL and testbench
==================================

Name: simple_bus_node

Overview:
- Single-bit bus endpoint carrying a parameter set, modelled on the `simple_bus` interface and its `mp` modport (input `a`).
- Exposes its own derived parameter values as constant outputs, so parent modules and benches can read them as signals.
- Registers the bus bit, reports its rising and falling edges, and counts edges and high cycles.
- Instantiated once per bus leaf. Parent modules may set `PARAMETER` from another node's `PARAMETER` value, optionally with an offset added.

Parameters:
- PARAMETER, 0, base configuration value; 32-bit signed integer.
- PARAMETER_X, PARAMETER, overridable; the high-cycle threshold.
- PARAMETER_XX, 1000 + PARAMETER, overridable; exported constant.
- PARAMETER_Y (localparam), PARAMETER_X*2 + PARAMETER_XX, not overridable.
- PARAMETER_YY (localparam), 1000 + PARAMETER_XX, not overridable.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- a  in  1  bus bit (modport mp input)
- a_q  out  1  `a` registered one cycle
- rise  out  1  one-cycle pulse on a 0->1 transition of `a_q`
- fall  out  1  one-cycle pulse on a 1->0 transition of `a_q`
- edge_cnt  out  32  count of rising edges, saturating
- high_cnt  out  32  count of cycles with `a_q` = 1, saturating
- hit_x  out  1  high when `high_cnt` >= PARAMETER_X
- param_o  out  32  constant PARAMETER
- param_x_o  out  32  constant PARAMETER_X
- param_xx_o  out  32  constant PARAMETER_XX
- param_y_o  out  32  constant PARAMETER_Y
- param_yy_o  out  32  constant PARAMETER_YY

Behaviour:
- Reset, applied when `rst`=1 at a clock edge: `a_q`=0, an internal `a_qq`=0, `rise`=0, `fall`=0, `edge_cnt`=0, `high_cnt`=0. `hit_x` is combinational and follows `high_cnt` after reset.
- Reset asserted mid-operation takes priority over every update in that cycle.
- Pipeline:
  - `a_q` <= `a`; `a_qq` <= `a_q`.
  - `rise` = `a_q` & ~`a_qq` (combinational from registers), so it pulses 1 cycle after `a` rises.
  - `fall` = ~`a_q` & `a_qq`.
- `edge_cnt` increments on each clock where `rise`=1. It holds at 32'hFFFFFFFF (no wrap).
- `high_cnt` increments on each clock where `a_q`=1. It saturates the same way.
- `hit_x` = (`high_cnt` >= PARAMETER_X), unsigned compare with PARAMETER_X cast to 32 bits.
  - PARAMETER_X = 0 makes `hit_x`=1 always, including during reset.
- Parameter outputs:
  - Driven continuously and independent of clock and reset.
  - Values are truncated or sign-extended to 32 bits.
  - Derived values are elaborated strictly in declaration order: PARAMETER_X, PARAMETER_XX, PARAMETER_Y, PARAMETER_YY.
- Override rules:
  - Overriding PARAMETER alone re-derives all four dependents.
  - Overriding PARAMETER_X or PARAMETER_XX replaces only that value, and the localparams use the overridden value.
  - Any attempt to override PARAMETER_Y or PARAMETER_YY is an elaboration error.
- No X propagation: every register has a reset value.

Decomposition:
- Package `simple_bus_pkg`:
  - `cnt_t` (logic [31:0]) and `CNT_MAX` constant.
  - Function `derive_y(x, xx)` = x*2+xx, and function `derive_yy(xx)` = 1000+xx, used by the localparams.
- One natural sub-module: `sat_counter`, a 32-bit saturating counter with synchronous active-high clear and an increment enable. It is instantiated twice, for `edge_cnt` and `high_cnt`.
- Edge detection and parameter export stay in the top level.

Test Plan:
- Default parameters -> `param_o`=0, `param_x_o`=0, `param_xx_o`=1000, `param_y_o`=1000, `param_yy_o`=2000; `hit_x`=1 from time 0.
- PARAMETER=100 -> outputs 100, 100, 1100, 1300, 2100. A second instance with PARAMETER = first instance's PARAMETER + 100 -> 200, 200, 1200, 1600, 2200.
- PARAMETER=2; after reset drive `a`=1 for 3 cycles then 0:
  - `rise` pulses in cycle 2 and `fall` pulses in cycle 5.
  - `high_cnt` ends at 3 and `edge_cnt` ends at 1.
  - `hit_x` rises the cycle `high_cnt` reaches 2.
- Toggle `a` every cycle for 10 cycles -> `edge_cnt`=5 and `high_cnt`=5. Assert `rst` for one cycle mid-sequence -> both counters 0 the next cycle, and counting resumes afterwards.
- Force the counters near saturation (hierarchical preload to 32'hFFFFFFFE) with `a` held at 1 -> `high_cnt` reaches 32'hFFFFFFFF and stays there.
- Override PARAMETER_XX=5 with PARAMETER=1 -> `param_y_o`=7 and `param_yy_o`=1005. An override of PARAMETER_Y is rejected at elaboration.

Source files
------------

// File: rtl/simple_bus_pkg.sv
// Shared types and parameter-derivation helpers for simple_bus_node.
// The derivation functions keep localparam arithmetic in one place for every bus leaf.
package simple_bus_pkg;

   typedef logic [31:0] cnt_t;

   localparam cnt_t CNT_MAX = 32'hFFFF_FFFF;

   function automatic int derive_y(input int x, input int xx);
      return (x * 32'sd2) + xx;
   endfunction

   function automatic int derive_yy(input int xx);
      return 32'sd1000 + xx;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// 32-bit counter that holds at CNT_MAX instead of wrapping.
// A synchronous clear takes priority over the increment enable.
module sat_counter
   import simple_bus_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic inc,
   output cnt_t cnt
);

   cnt_t cnt_d;
   cnt_t cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 32'd0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/simple_bus_node.sv
// Single-bit bus leaf: registers the bus bit, flags its edges, counts edges and high
// cycles, and exports its own parameter set as constant 32-bit outputs.
module simple_bus_node
   import simple_bus_pkg::*;
#(
   parameter int PARAMETER    = 0,
   parameter int PARAMETER_X  = PARAMETER,
   parameter int PARAMETER_XX = 32'sd1000 + PARAMETER
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        a,
   output logic        a_q,
   output logic        rise,
   output logic        fall,
   output logic [31:0] edge_cnt,
   output logic [31:0] high_cnt,
   output logic        hit_x,
   output logic [31:0] param_o,
   output logic [31:0] param_x_o,
   output logic [31:0] param_xx_o,
   output logic [31:0] param_y_o,
   output logic [31:0] param_yy_o
);

   localparam int   PARAMETER_Y  = derive_y(PARAMETER_X, PARAMETER_XX);
   localparam int   PARAMETER_YY = derive_yy(PARAMETER_XX);
   localparam cnt_t X_THRESHOLD  = cnt_t'(PARAMETER_X);

   logic a_d;
   // a_prev_q is the second pipeline stage (a_q delayed by one more cycle).
   logic a_prev_d;
   logic a_prev_q;

   always_comb begin
      a_d      = a;
      a_prev_d = a_q;
      if (rst) begin
         a_d      = 1'b0;
         a_prev_d = 1'b0;
      end else begin
         a_d      = a;
         a_prev_d = a_q;
      end
   end

   always_ff @(posedge clk) begin
      a_q      <= a_d;
      a_prev_q <= a_prev_d;
   end

   assign rise = a_q & ~a_prev_q;
   assign fall = ~a_q & a_prev_q;

   sat_counter u_edge_cnt (
      .clk (clk),
      .clr (rst),
      .inc (rise),
      .cnt (edge_cnt)
   );

   sat_counter u_high_cnt (
      .clk (clk),
      .clr (rst),
      .inc (a_q),
      .cnt (high_cnt)
   );

   // A zero threshold is met unconditionally, even while the counter is being cleared.
   assign hit_x = (X_THRESHOLD == 32'd0) || (high_cnt >= X_THRESHOLD);

   assign param_o    = 32'(PARAMETER);
   assign param_x_o  = 32'(PARAMETER_X);
   assign param_xx_o = 32'(PARAMETER_XX);
   assign param_y_o  = 32'(PARAMETER_Y);
   assign param_yy_o = 32'(PARAMETER_YY);

endmodule

// File: tb/tb_simple_bus_node.sv
// Self-checking bench for simple_bus_node: five parameterisations share one bus bit and
// are compared each cycle against a cycle-level behavioural model of the node.
module tb_simple_bus_node;

   localparam int P1 = 100;
   localparam int P2 = P1 + 100;
   localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;
   localparam int NI = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a   = 1'b0;

   always #5 clk = ~clk;

   logic [NI-1:0] aq_o;
   logic [NI-1:0] rise_o;
   logic [NI-1:0] fall_o;
   logic [NI-1:0] hit_o;
   logic [31:0]   ec_o   [NI];
   logic [31:0]   hc_o   [NI];
   logic [31:0]   p_o    [NI];
   logic [31:0]   px_o   [NI];
   logic [31:0]   pxx_o  [NI];
   logic [31:0]   py_o   [NI];
   logic [31:0]   pyy_o  [NI];

   // Expected constants, worked out by hand from the parameter rules.
   int exp_p   [NI] = '{0,    100,  200,  1,    2};
   int exp_x   [NI] = '{0,    100,  200,  1,    2};
   int exp_xx  [NI] = '{1000, 1100, 1200, 5,    1002};
   int exp_y   [NI] = '{1000, 1300, 1600, 7,    1006};
   int exp_yy  [NI] = '{2000, 2100, 2200, 1005, 2002};

   int n_chk  = 0;
   int n_fail = 0;

   // Model state: last two sampled bus values plus per-instance counters.
   logic            m_aq  = 1'b0;
   logic            m_aqq = 1'b0;
   longint unsigned m_edge [NI];
   longint unsigned m_high [NI];

   simple_bus_node u_def (
      .clk(clk), .rst(rst), .a(a), .a_q(aq_o[0]), .rise(rise_o[0]), .fall(fall_o[0]),
      .edge_cnt(ec_o[0]), .high_cnt(hc_o[0]), .hit_x(hit_o[0]), .param_o(p_o[0]),
      .param_x_o(px_o[0]), .param_xx_o(pxx_o[0]), .param_y_o(py_o[0]), .param_yy_o(pyy_o[0])
   );

   simple_bus_node #(.PARAMETER(P1)) u_p100 (
      .clk(clk), .rst(rst), .a(a), .a_q(aq_o[1]), .rise(rise_o[1]), .fall(fall_o[1]),
      .edge_cnt(ec_o[1]), .high_cnt(hc_o[1]), .hit_x(hit_o[1]), .param_o(p_o[1]),
      .param_x_o(px_o[1]), .param_xx_o(pxx_o[1]), .param_y_o(py_o[1]), .param_yy_o(pyy_o[1])
   );

   simple_bus_node #(.PARAMETER(P2)) u_p200 (
      .clk(clk), .rst(rst), .a(a), .a_q(aq_o[2]), .rise(rise_o[2]), .fall(fall_o[2]),
      .edge_cnt(ec_o[2]), .high_cnt(hc_o[2]), .hit_x(hit_o[2]), .param_o(p_o[2]),
      .param_x_o(px_o[2]), .param_xx_o(pxx_o[2]), .param_y_o(py_o[2]), .param_yy_o(pyy_o[2])
   );

   simple_bus_node #(.PARAMETER(1), .PARAMETER_XX(5)) u_xx (
      .clk(clk), .rst(rst), .a(a), .a_q(aq_o[3]), .rise(rise_o[3]), .fall(fall_o[3]),
      .edge_cnt(ec_o[3]), .high_cnt(hc_o[3]), .hit_x(hit_o[3]), .param_o(p_o[3]),
      .param_x_o(px_o[3]), .param_xx_o(pxx_o[3]), .param_y_o(py_o[3]), .param_yy_o(pyy_o[3])
   );

   simple_bus_node #(.PARAMETER(2)) dut (
      .clk(clk), .rst(rst), .a(a), .a_q(aq_o[4]), .rise(rise_o[4]), .fall(fall_o[4]),
      .edge_cnt(ec_o[4]), .high_cnt(hc_o[4]), .hit_x(hit_o[4]), .param_o(p_o[4]),
      .param_x_o(px_o[4]), .param_xx_o(pxx_o[4]), .param_y_o(py_o[4]), .param_yy_o(pyy_o[4])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic e_rise;
      logic e_fall;
      e_rise = m_aq & ~m_aqq;
      e_fall = ~m_aq & m_aqq;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("a_q[%0d]", i),      32'(aq_o[i]),   32'(m_aq));
         chk($sformatf("rise[%0d]", i),     32'(rise_o[i]), 32'(e_rise));
         chk($sformatf("fall[%0d]", i),     32'(fall_o[i]), 32'(e_fall));
         chk($sformatf("edge_cnt[%0d]", i), ec_o[i],        m_edge[i][31:0]);
         chk($sformatf("high_cnt[%0d]", i), hc_o[i],        m_high[i][31:0]);
         chk($sformatf("hit_x[%0d]", i),    32'(hit_o[i]),
             32'(m_high[i] >= longint'(exp_x[i])));
      end
   endtask

   // One clock: drive at the falling edge, advance the model at the rising edge, check after it.
   task automatic step(input logic av, input logic rv);
      @(negedge clk);
      a   = av;
      rst = rv;
      @(posedge clk);
      if (rv) begin
         m_aq  = 1'b0;
         m_aqq = 1'b0;
         for (int i = 0; i < NI; i++) begin
            m_edge[i] = 0;
            m_high[i] = 0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (m_aq && !m_aqq) m_edge[i] = (m_edge[i] < MAXV) ? m_edge[i] + 1 : MAXV;
            if (m_aq)           m_high[i] = (m_high[i] < MAXV) ? m_high[i] + 1 : MAXV;
         end
         m_aqq = m_aq;
         m_aq  = av;
      end
      #1;
      check_all();
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         m_edge[i] = 0;
         m_high[i] = 0;
      end

      #1;
      // Parameter exports are constants, valid before any clock edge.
      chk("def_hit_x_t0", 32'(hit_o[0]), 32'd1);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("param_o[%0d]", i),    p_o[i],   32'(exp_p[i]));
         chk($sformatf("param_x_o[%0d]", i),  px_o[i],  32'(exp_x[i]));
         chk($sformatf("param_xx_o[%0d]", i), pxx_o[i], 32'(exp_xx[i]));
         chk($sformatf("param_y_o[%0d]", i),  py_o[i],  32'(exp_y[i]));
         chk($sformatf("param_yy_o[%0d]", i), pyy_o[i], 32'(exp_yy[i]));
      end

      step(1'b1, 1'b1);
      step(1'b0, 1'b1);

      // a high for three cycles, then low.
      step(1'b1, 1'b0);
      chk("plan_rise_c2", 32'(rise_o[4]), 32'd1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("plan_hit_at_2", 32'(hit_o[4]), 32'd1);
      step(1'b0, 1'b0);
      chk("plan_fall_c5", 32'(fall_o[4]), 32'd1);
      step(1'b0, 1'b0);
      chk("plan_high_end", hc_o[4], 32'd3);
      chk("plan_edge_end", ec_o[4], 32'd1);

      // Toggle for ten cycles from a clean reset.
      step(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(((i % 2) == 0), 1'b0);
      chk("toggle_edge", ec_o[4], 32'd5);
      chk("toggle_high", hc_o[4], 32'd5);

      // Toggle again with a one-cycle reset in the middle.
      for (int i = 0; i < 10; i++) begin
         step(((i % 2) == 0), (i == 4));
         if (i == 4) begin
            chk("midrst_edge", ec_o[4], 32'd0);
            chk("midrst_high", hc_o[4], 32'd0);
         end
      end

      // Random bus traffic with occasional resets.
      for (int i = 0; i < 150; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      end

      // High counter saturation.
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      force dut.u_high_cnt.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.u_high_cnt.cnt_q;
      m_high[4] = 64'h0000_0000_FFFF_FFFE;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      chk("high_sat", hc_o[4], 32'hFFFF_FFFF);

      // Edge counter saturation.
      force dut.u_edge_cnt.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.u_edge_cnt.cnt_q;
      m_edge[4] = 64'h0000_0000_FFFF_FFFE;
      for (int i = 0; i < 8; i++) step(((i % 2) == 1), 1'b0);
      chk("edge_sat", ec_o[4], 32'hFFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
